// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue/sequencing stage for the 32-bit ALU with a multi-cycle unsigned divider
module alu_issue #(
    parameter int WIDTH  = 32,
    parameter int DIV_OP = 19,
    parameter int REM_OP = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [7:0]       alu_op,
    output logic             alu_carry_in,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_carry_out,
    input  logic             alu_is_zero,
    input  logic             alu_is_negative
);

    localparam logic [4:0] LP_DIV_CODE = DIV_OP[4:0];
    localparam logic [4:0] LP_REM_CODE = REM_OP[4:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic             w_issue_alu;
    logic             w_issue_div;
    logic             w_is_div_op;

    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [7:0]       r_alu_op;
    logic             r_alu_carry_in;
    logic [WIDTH-1:0] r_result;
    logic             r_flag_c;
    logic             r_flag_z;
    logic             r_flag_n;
    logic             r_done;

    // Divider: r_q starts as the dividend and fills with quotient bits from the LSB.
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [4:0]       r_count;
    logic             r_is_rem;
    logic             r_div_zero;

    logic [WIDTH:0]   w_partial;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_div_res;
    logic [WIDTH-1:0] w_dz_res;

    assign w_is_div_op = (op[4:0] == LP_DIV_CODE) || (op[4:0] == LP_REM_CODE);

    assign w_partial  = {r_rem, r_q[WIDTH-1]};
    assign w_trial    = w_partial - {1'b0, r_divisor};
    assign w_fits     = ~w_trial[WIDTH];
    assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : w_partial[WIDTH-1:0];
    assign w_q_next   = {r_q[WIDTH-2:0], w_fits};
    assign w_div_res  = r_is_rem ? w_rem_next : w_q_next;
    assign w_dz_res   = r_is_rem ? r_q : {WIDTH{1'b1}};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue_alu  = 1'b0;
        w_issue_div  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_is_div_op) begin
                        w_issue_div  = 1'b1;
                        w_state_next = ST_DIV;
                    end else begin
                        w_issue_alu  = 1'b1;
                        w_state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: w_state_next = ST_IDLE;
            ST_DIV: begin
                if (r_div_zero || (r_count == 5'd0)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= '0;
            r_alu_carry_in <= 1'b0;
            r_result       <= '0;
            r_flag_c       <= 1'b0;
            r_flag_z       <= 1'b0;
            r_flag_n       <= 1'b0;
            r_done         <= 1'b0;
            r_q            <= '0;
            r_rem          <= '0;
            r_divisor      <= '0;
            r_count        <= '0;
            r_is_rem       <= 1'b0;
            r_div_zero     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_issue_alu) begin
                r_alu_a        <= a_in;
                r_alu_b        <= b_in;
                r_alu_op       <= op;
                r_alu_carry_in <= r_flag_c;
            end
            if (w_issue_div) begin
                r_q        <= a_in;
                r_rem      <= '0;
                r_divisor  <= b_in;
                r_count    <= 5'd31;
                r_is_rem   <= (op[4:0] == LP_REM_CODE);
                r_div_zero <= (b_in == '0);
            end
            if (r_state == ST_EXEC) begin
                r_result <= alu_c;
                r_flag_c <= alu_carry_out;
                r_flag_z <= alu_is_zero;
                r_flag_n <= alu_is_negative;
                r_done   <= 1'b1;
            end
            if (r_state == ST_DIV) begin
                if (r_div_zero) begin
                    r_result <= w_dz_res;
                    r_flag_c <= 1'b1;
                    r_flag_z <= (w_dz_res == '0);
                    r_flag_n <= w_dz_res[WIDTH-1];
                    r_done   <= 1'b1;
                end else begin
                    r_q     <= w_q_next;
                    r_rem   <= w_rem_next;
                    r_count <= r_count - 5'd1;
                    if (r_count == 5'd0) begin
                        r_result <= w_div_res;
                        r_flag_c <= 1'b0;
                        r_flag_z <= (w_div_res == '0);
                        r_flag_n <= w_div_res[WIDTH-1];
                        r_done   <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign result       = r_result;
    assign flag_c       = r_flag_c;
    assign flag_z       = r_flag_z;
    assign flag_n       = r_flag_n;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign alu_carry_in = r_alu_carry_in;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue with a small ALU model
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        flag_c;
    logic        flag_z;
    logic        flag_n;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [7:0]  alu_op;
    logic        alu_carry_in;
    logic [31:0] alu_c;
    logic        alu_carry_out;
    logic        alu_is_zero;
    logic        alu_is_negative;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .op              (op),
        .a_in            (a_in),
        .b_in            (b_in),
        .busy            (busy),
        .done            (done),
        .result          (result),
        .flag_c          (flag_c),
        .flag_z          (flag_z),
        .flag_n          (flag_n),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_op          (alu_op),
        .alu_carry_in    (alu_carry_in),
        .alu_c           (alu_c),
        .alu_carry_out   (alu_carry_out),
        .alu_is_zero     (alu_is_zero),
        .alu_is_negative (alu_is_negative)
    );

    // ALU model: 0 = add, 1 = add with carry, 12 = shift left; anything else yields 0.
    always_comb begin
        {alu_carry_out, alu_c} = 33'd0;
        case (alu_op[4:0])
            5'd0:  {alu_carry_out, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
            5'd1:  {alu_carry_out, alu_c} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_carry_in};
            5'd12: alu_c = alu_a << alu_b[4:0];
            default: ;
        endcase
        alu_is_zero     = (alu_c == 32'd0);
        alu_is_negative = alu_c[31];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        step();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            step();
            lat++;
        end
    endtask

    int lat;
    int pulses;
    int done_at;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 8'd0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        step(); step(); step();
        reset = 1'b0;

        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
        chk("reset_alu_ports", {alu_a[15:0], alu_b[7:0], alu_op}, 32'd0);

        run(8'd0, 32'd5, 32'd7, lat);
        chk("add_latency", lat, 2);
        chk("add_result", result, 32'd12);
        chk("add_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
        step();
        chk("add_done_pulse", {31'd0, done}, 32'd0);
        chk("add_result_hold", result, 32'd12);

        run(8'd0, 32'hFFFF_FFFF, 32'd1, lat);
        chk("carry_latency", lat, 2);
        chk("carry_result", result, 32'd0);
        chk("carry_flags", {29'd0, flag_c, flag_z, flag_n}, 32'b110);
        start = 1'b1; op = 8'd1; a_in = 32'd0; b_in = 32'd0;
        step();
        start = 1'b0;
        chk("b2b_carry_in", {31'd0, alu_carry_in}, 32'd1);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        step();
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_result", result, 32'd1);
        chk("b2b_flags", {29'd0, flag_c, flag_z, flag_n}, 32'b000);

        run(8'd19, 32'd100, 32'd7, lat);
        chk("div_latency", lat, 33);
        chk("div_result", result, 32'd14);
        chk("div_flags", {29'd0, flag_c, flag_z, flag_n}, 32'b000);
        chk("div_alu_op_held", {24'd0, alu_op}, 32'd1);
        run(8'd20, 32'd100, 32'd7, lat);
        chk("rem_latency", lat, 33);
        chk("rem_result", result, 32'd2);
        run(8'd19, 32'h8000_0000, 32'd1, lat);
        chk("div_msb_result", result, 32'h8000_0000);
        chk("div_msb_flags", {29'd0, flag_c, flag_z, flag_n}, 32'b001);

        run(8'd19, 32'd9, 32'd0, lat);
        chk("dz_div_latency", lat, 2);
        chk("dz_div_result", result, 32'hFFFF_FFFF);
        chk("dz_div_flags", {29'd0, flag_c, flag_z, flag_n}, 32'b101);
        run(8'd20, 32'd9, 32'd0, lat);
        chk("dz_rem_latency", lat, 2);
        chk("dz_rem_result", result, 32'd9);
        chk("dz_rem_flags", {29'd0, flag_c, flag_z, flag_n}, 32'b100);
        step();

        pulses  = 0;
        done_at = 0;
        for (int k = 1; k <= 40; k++) begin
            start = (k == 1) || (k == 5);
            op    = (k == 1) ? 8'd19 : 8'd0;
            a_in  = (k == 1) ? 32'd100 : 32'd5;
            b_in  = 32'd7;
            step();
            if (done) begin
                pulses++;
                done_at = k;
            end
        end
        start = 1'b0;
        chk("busy_reject_pulses", pulses, 1);
        chk("busy_reject_done_at", done_at, 33);
        chk("busy_reject_result", result, 32'd14);
        chk("busy_reject_alu_a", alu_a, 32'd0);

        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            start = (k == 1);
            op    = 8'd19;
            a_in  = 32'd100;
            b_in  = 32'd7;
            reset = (k == 10);
            step();
            if (k == 10) begin
                chk("abort_result", result, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
                chk("abort_alu_ports", {alu_a[15:0], alu_b[7:0], alu_op}, 32'd0);
            end
            if (done) pulses++;
        end
        start = 1'b0;
        reset = 1'b0;
        chk("abort_no_done", pulses, 0);
        run(8'd0, 32'd5, 32'd7, lat);
        chk("post_abort_latency", lat, 2);
        chk("post_abort_result", result, 32'd12);

        run(8'd12, 32'd1, 32'd31, lat);
        chk("shl_result", result, 32'h8000_0000);
        chk("shl_flags", {29'd0, flag_c, flag_z, flag_n}, 32'b001);
        run(8'd25, 32'd3, 32'd4, lat);
        chk("unknown_latency", lat, 2);
        chk("unknown_result", result, 32'd0);
        chk("unknown_flags", {29'd0, flag_c, flag_z, flag_n}, 32'b010);
        chk("unknown_alu_op", {24'd0, alu_op}, 32'd25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
